// File: rtl/pbs_pkg.sv
// Shared types and constants for the battle datapath (resolver, CPU picker).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pbs_pkg;

  // Attack resolver FSM states, 2-bit encoding.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROLL  = 2'd1,
    APPLY = 2'd2,
    OVER  = 2'd3
  } resolver_state_t;

  localparam int          HP_INIT_DEF   = 40;
  localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;

  // Side encoding for attacker / winner.
  localparam logic PLAYER = 1'b0;
  localparam logic CPU    = 1'b1;

  // One step of the 16-bit Fibonacci LFSR, taps 16,14,13,11.
  function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
    logic fb;
    fb = cur[15] ^ cur[13] ^ cur[12] ^ cur[10];
    return {cur[14:0], fb};
  endfunction

endpackage

// File: rtl/battle_lfsr.sv
// Free-running 16-bit pseudo-random source for hit rolls and CPU move picks.
// Latency: new value every cycle; SEED visible the cycle after reset.
// Backpressure: none, never stalls.
module battle_lfsr
  import pbs_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED_DEF
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] rnd
);

  // Load the seed on reset, otherwise advance one step per cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rnd <= SEED;
    end else begin
      rnd <= lfsr_step(rnd);
    end
  end

endmodule

// File: rtl/attack_resolver.sv
// Resolves one attack: hit roll against accuracy, saturating HP damage, faint detection.
// Latency: start at edge N -> HP/hit/done at edge N+2; next start accepted from N+2.
// Backpressure: start outside IDLE (or the final APPLY edge) is dropped, not queued.
module attack_resolver
  import pbs_pkg::*;
#(
  parameter int          HP_W      = 6,
  parameter int          HP_INIT   = HP_INIT_DEF,
  parameter logic [15:0] LFSR_SEED = LFSR_SEED_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            attacker,
  input  logic [3:0]      dmg,
  input  logic [3:0]      accu,
  output logic [HP_W-1:0] p_hp,
  output logic [HP_W-1:0] c_hp,
  output logic            busy,
  output logic            done,
  output logic            hit,
  output logic            game_over,
  output logic            winner
);

  localparam logic [HP_W-1:0] HP_RST = HP_W'(HP_INIT);

  resolver_state_t state, state_nxt;

  logic            att_l;
  logic [3:0]      dmg_l;
  logic [3:0]      accu_l;
  logic            hit_nxt;
  logic            take;

  logic [HP_W-1:0] def_hp;
  logic [HP_W-1:0] dmg_ext;
  logic [HP_W-1:0] def_new;
  logic            def_dead;

  logic [15:0]     lfsr_val;
  logic            lfsr_unused;

  battle_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .rnd   (lfsr_val)
  );

  // Only the low nibble is the hit roll; the rest is for other consumers.
  assign lfsr_unused = ^lfsr_val[15:4];

  assign busy = (state == ROLL) || (state == APPLY);

  // Defender's HP after this attack, saturating at zero.
  always_comb begin
    def_hp   = (att_l == CPU) ? p_hp : c_hp;
    dmg_ext  = HP_W'(dmg_l);
    def_new  = def_hp;
    if (hit_nxt) begin
      def_new = (def_hp > dmg_ext) ? (def_hp - dmg_ext) : '0;
    end
    def_dead = (def_new == '0);
  end

  // Next-state logic; a start on the APPLY edge chains straight into ROLL
  // so attacks can be issued every two cycles.
  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    case (state)
      IDLE: begin
        if (start && !game_over) begin
          take      = 1'b1;
          state_nxt = ROLL;
        end
      end
      ROLL: begin
        state_nxt = APPLY;
      end
      APPLY: begin
        if (def_dead) begin
          state_nxt = OVER;
        end else if (start) begin
          take      = 1'b1;
          state_nxt = ROLL;
        end else begin
          state_nxt = IDLE;
        end
      end
      OVER: begin
        state_nxt = OVER;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Operand latch, hit roll and HP/result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      att_l     <= PLAYER;
      dmg_l     <= '0;
      accu_l    <= '0;
      hit_nxt   <= 1'b0;
      p_hp      <= HP_RST;
      c_hp      <= HP_RST;
      done      <= 1'b0;
      hit       <= 1'b0;
      game_over <= 1'b0;
      winner    <= 1'b0;
    end else begin
      done <= (state == APPLY);
      if (take) begin
        att_l  <= attacker;
        dmg_l  <= dmg;
        accu_l <= accu;
      end
      if (state == ROLL) begin
        hit_nxt <= (lfsr_val[3:0] <= accu_l);
      end
      if (state == APPLY) begin
        hit <= hit_nxt;
        if (att_l == CPU) begin
          p_hp <= def_new;
        end else begin
          c_hp <= def_new;
        end
        if (def_dead) begin
          game_over <= 1'b1;
          winner    <= att_l;
        end
      end
    end
  end

endmodule
